game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//   Game controller downstream of the bird physics block and pipe generator.
//   Consumes bird and pipe bounding boxes once per frame, detects collisions,
//   counts pipes cleared (BCD score), and runs the IDLE/PLAYING/DYING/OVER flow.
//   Generates the flap pulse, game reset pulse and animate enable that drive
//   the physics and pipe stages. Also drives the score overlay.
// PARAMETERS
//   GROUND_Y    450  bird bottom edge >= this value counts as a ground collision
//   DEATH_FRAMES 60  frames spent in DYING before OVER (1..255)
//   SYNC_STAGES  2   button synchroniser depth (>=2)
// PORTS
//   i_clk        in   1   base clock; only clock in the block
//   i_rst        in   1   synchronous, active-high reset
//   i_ani_stb    in   1   frame strobe, 1 cycle per frame
//   i_btn        in   1   flap button, asynchronous, already debounced
//   i_bx1,i_bx2  in   12  bird left/right edge (unsigned)
//   i_by1,i_by2  in   12  bird top/bottom edge (unsigned)
//   i_px1,i_px2  in   12  pipe left/right edge (unsigned)
//   i_hy1,i_hy2  in   12  pipe hole top/bottom edge (unsigned, hy1 < hy2)
//   o_flap       out  1   1-cycle flap pulse to bird physics
//   o_game_rst   out  1   1-cycle reset pulse to bird/pipe stages
//   o_animate    out  1   high only in PLAYING
//   o_game_over  out  1   high only in OVER
//   o_score      out  8   BCD score {tens,units}, 00..99
//   o_state      out  2   IDLE=0 PLAYING=1 DYING=2 OVER=3
// BEHAVIOUR
//   Reset: state IDLE; o_score=8'h00; all 1-bit outputs 0; passed flag 0;
//     death counter 0; synchroniser flops 0. All outputs registered.
//   Button: SYNC_STAGES-flop sync, then rising-edge detect -> press (1 cycle).
//     With SYNC_STAGES=2, press registered output appears 3 cycles after i_btn rises.
//   IDLE: press -> PLAYING; same cycle-edge asserts o_game_rst and o_flap (1 cycle
//     each), clears o_score and passed flag.
//   PLAYING: each press -> o_flap pulse. Evaluation only on i_ani_stb cycles:
//     hov  = (i_bx2 >= i_px1) && (i_bx1 <= i_px2)
//     hit  = (hov && (i_by1 < i_hy1 || i_by2 > i_hy2)) || (i_by2 >= GROUND_Y)
//            || (i_by1 > i_by2)  // wrapped box treated as top-of-screen hit
//     clear= !passed && (i_bx1 > i_px2)
//     hit -> DYING next cycle, score unchanged (hit beats clear same frame).
//     else clear -> passed<=1, score BCD+1, saturates at 99 (no wrap).
//     passed<=0 when i_px1 > i_bx2 (pipe respawned right of bird).
//   DYING: o_animate=0; presses ignored (no o_flap); counter counts i_ani_stb;
//     after DEATH_FRAMES strobes -> OVER.
//   OVER: o_game_over=1; score held; press -> IDLE (no o_game_rst; that is
//     issued on IDLE->PLAYING).
//   Press and i_ani_stb same cycle in PLAYING: both processed (flap and eval).
//   i_rst mid-game: returns to IDLE next edge regardless of state; no pulses.
//   BCD increment: units 9 -> 0 with tens+1; 8'h99 stays 8'h99.
// TESTING
//   Reset then i_btn rise -> o_flap, o_game_rst 1-cycle pulses 3 clk later,
//     o_state=1, o_animate=1, o_score=00.
//   PLAYING, bird x 300..340 y 200..240, pipe x 280..320 hole 180..260, stb ->
//     no hit; move bird y 150..190, stb -> o_state=2 next cycle, score held.
//   Bird bx1=330, pipe px2=320, stb -> score 01; repeated stbs -> stays 01;
//     set px1=600 then px2=320 again -> score 02.
//   Preload score 09 -> clear -> 10; preload 99 -> clear -> stays 99.
//   Hit and clear on same stb -> DYING, score unchanged; DYING + 60 stbs ->
//     o_state=3, o_game_over=1; btn in DYING -> no o_flap.
//   Assert i_rst in PLAYING/DYING/OVER -> IDLE next edge, all outputs reset.

Source files
------------

// File: rtl/game_ctrl.sv
// Game flow controller: button sync, collision/score evaluation per frame and
// the IDLE/PLAYING/DYING/OVER sequencing with registered control pulses.
module game_ctrl #(
  parameter logic [11:0] GROUND_Y     = 12'd450,
  parameter logic [7:0]  DEATH_FRAMES = 8'd60,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_btn,
  input  logic [11:0] i_bx1,
  input  logic [11:0] i_bx2,
  input  logic [11:0] i_by1,
  input  logic [11:0] i_by2,
  input  logic [11:0] i_px1,
  input  logic [11:0] i_px2,
  input  logic [11:0] i_hy1,
  input  logic [11:0] i_hy2,
  output logic        o_flap,
  output logic        o_game_rst,
  output logic        o_animate,
  output logic        o_game_over,
  output logic [7:0]  o_score,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_DYING   = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_btn_d;
  logic                   w_press;
  logic                   r_passed;
  logic                   w_passed_nxt;
  logic [7:0]             r_death_cnt;
  logic [7:0]             w_death_cnt_nxt;
  logic [7:0]             w_score_nxt;
  logic                   w_flap_nxt;
  logic                   w_game_rst_nxt;
  logic                   w_hov;
  logic                   w_hit;
  logic                   w_clear;

  // BCD +1 that saturates at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign w_press = r_sync[SYNC_STAGES-1] & ~r_btn_d;
  assign w_hov   = (i_bx2 >= i_px1) && (i_bx1 <= i_px2);
  // A box with top below bottom has wrapped past the top of the screen.
  assign w_hit   = (w_hov && ((i_by1 < i_hy1) || (i_by2 > i_hy2)))
                 || (i_by2 >= GROUND_Y) || (i_by1 > i_by2);
  assign w_clear = !r_passed && (i_bx1 > i_px2);
  assign o_state = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_passed_nxt    = r_passed;
    w_death_cnt_nxt = r_death_cnt;
    w_score_nxt     = o_score;
    w_flap_nxt      = 1'b0;
    w_game_rst_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_state_nxt    = S_PLAYING;
          w_flap_nxt     = 1'b1;
          w_game_rst_nxt = 1'b1;
          w_score_nxt    = 8'h00;
          w_passed_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PLAYING: begin
        w_flap_nxt = w_press;
        if (i_ani_stb) begin
          if (w_hit) begin
            w_state_nxt     = S_DYING;
            w_death_cnt_nxt = 8'd0;
          end else if (w_clear) begin
            w_passed_nxt = 1'b1;
            w_score_nxt  = bcd_inc(o_score);
          end else if (i_px1 > i_bx2) begin
            w_passed_nxt = 1'b0;
          end else begin
            w_passed_nxt = r_passed;
          end
        end else begin
          w_state_nxt = S_PLAYING;
        end
      end
      S_DYING: begin
        if (i_ani_stb) begin
          if (r_death_cnt == DEATH_FRAMES - 8'd1) begin
            w_state_nxt     = S_OVER;
            w_death_cnt_nxt = 8'd0;
          end else begin
            w_death_cnt_nxt = r_death_cnt + 8'd1;
          end
        end else begin
          w_state_nxt = S_DYING;
        end
      end
      S_OVER: begin
        if (w_press) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sync      <= '0;
      r_btn_d     <= 1'b0;
      r_passed    <= 1'b0;
      r_death_cnt <= 8'd0;
      o_score     <= 8'h00;
      o_flap      <= 1'b0;
      o_game_rst  <= 1'b0;
      o_animate   <= 1'b0;
      o_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_btn_d     <= r_sync[SYNC_STAGES-1];
      r_passed    <= w_passed_nxt;
      r_death_cnt <= w_death_cnt_nxt;
      o_score     <= w_score_nxt;
      o_flap      <= w_flap_nxt;
      o_game_rst  <= w_game_rst_nxt;
      o_animate   <= (w_state_nxt == S_PLAYING);
      o_game_over <= (w_state_nxt == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scenario bench for game_ctrl: expectations are queued as stimulus is applied
// and popped for comparison once the registered outputs settle.
module tb_game_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_ani_stb;
  logic        i_btn;
  logic [11:0] i_bx1, i_bx2, i_by1, i_by2;
  logic [11:0] i_px1, i_px2, i_hy1, i_hy2;
  logic        o_flap, o_game_rst, o_animate, o_game_over;
  logic [7:0]  o_score;
  logic [1:0]  o_state;
  logic [13:0] obs;

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  game_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_btn(i_btn),
    .i_bx1(i_bx1), .i_bx2(i_bx2), .i_by1(i_by1), .i_by2(i_by2),
    .i_px1(i_px1), .i_px2(i_px2), .i_hy1(i_hy1), .i_hy2(i_hy2),
    .o_flap(o_flap), .o_game_rst(o_game_rst), .o_animate(o_animate),
    .o_game_over(o_game_over), .o_score(o_score), .o_state(o_state)
  );

  assign obs = {o_state, o_score, o_animate, o_game_over, o_flap, o_game_rst};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected output vector; score given in decimal and saturated at 99.
  function automatic logic [13:0] mk(input logic [1:0] st, input int sc,
                                     input logic fl, input logic gr);
    int s;
    logic [7:0] b;
    s = (sc > 99) ? 99 : sc;
    b = {4'(s / 10), 4'(s % 10)};
    return {st, b, st == 2'd1, st == 2'd3, fl, gr};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic stb();
    i_ani_stb = 1'b1;
    tick();
    i_ani_stb = 1'b0;
  endtask

  // Raise the button, capture outputs when the pulse should be visible, release.
  task automatic press(output logic [13:0] at_pulse);
    i_btn = 1'b1;
    tick(); tick(); tick();
    at_pulse = obs;
    i_btn = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic set_bird(input int x1, input int x2, input int y1, input int y2);
    i_bx1 = 12'(x1); i_bx2 = 12'(x2); i_by1 = 12'(y1); i_by2 = 12'(y2);
  endtask

  task automatic set_pipe(input int x1, input int x2);
    i_px1 = 12'(x1); i_px2 = 12'(x2); i_hy1 = 12'd180; i_hy2 = 12'd260;
  endtask

  task automatic restart();
    logic [13:0] p;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    set_bird(300, 340, 200, 240);
    set_pipe(280, 320);
    press(p);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    q.push_back('{"reset", mk(2'd0, 0, 1'b0, 1'b0)});
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    logic [13:0] p;
    set_bird(300, 340, 200, 240);
    set_pipe(280, 320);
    q.push_back('{"start_pulse", mk(2'd1, 0, 1'b1, 1'b1)});
    press(p);
    e = q.pop_front(); checks++;
    if (p !== e.v) $display("FAIL %s: got %h expected %h", e.name, p, e.v); else passes++;
    q.push_back('{"start_settled", mk(2'd1, 0, 1'b0, 1'b0)});
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    q.push_back('{"play_flap", mk(2'd1, 0, 1'b1, 1'b0)});
    press(p);
    e = q.pop_front(); checks++;
    if (p !== e.v) $display("FAIL %s: got %h expected %h", e.name, p, e.v); else passes++;
  endtask

  task automatic test_collision();
    // {bird y1, bird y2, pipe x1, pipe x2, expected state}
    int tbl [6][5] = '{
      '{200, 240, 280, 320, 1},   // inside hole
      '{180, 260, 280, 320, 1},   // exactly on hole edges
      '{409, 449, 600, 640, 1},   // one above ground
      '{150, 190, 280, 320, 2},   // hits pipe top
      '{410, 450, 600, 640, 2},   // ground
      '{240, 200, 600, 640, 2}    // wrapped box
    };
    for (int i = 0; i < 6; i++) begin
      restart();
      set_bird(300, 340, tbl[i][0], tbl[i][1]);
      set_pipe(tbl[i][2], tbl[i][3]);
      q.push_back('{$sformatf("collision_%0d", i), mk(2'(tbl[i][4]), 0, 1'b0, 1'b0)});
      stb();
      e = q.pop_front(); checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    end
  endtask

  task automatic test_clear();
    restart();
    set_bird(330, 370, 200, 240);
    q.push_back('{"clear_first", mk(2'd1, 1, 1'b0, 1'b0)});
    stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    q.push_back('{"clear_hold", mk(2'd1, 1, 1'b0, 1'b0)});
    stb(); stb(); stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    set_pipe(600, 640);
    stb();
    set_pipe(280, 320);
    q.push_back('{"clear_second", mk(2'd1, 2, 1'b0, 1'b0)});
    stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
  endtask

  task automatic test_bcd();
    restart();
    set_bird(330, 370, 200, 240);
    for (int n = 1; n <= 101; n++) begin
      set_pipe(280, 320);
      q.push_back('{$sformatf("bcd_%0d", n), mk(2'd1, n, 1'b0, 1'b0)});
      stb();
      e = q.pop_front(); checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
      set_pipe(600, 640);
      stb();
    end
  endtask

  task automatic test_dying_over();
    logic [13:0] p;
    restart();
    set_bird(330, 370, 200, 240);
    stb();
    set_pipe(600, 640);
    stb();
    set_pipe(280, 320);
    set_bird(330, 370, 410, 450);
    q.push_back('{"hit_beats_clear", mk(2'd2, 1, 1'b0, 1'b0)});
    stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    q.push_back('{"dying_press", mk(2'd2, 1, 1'b0, 1'b0)});
    press(p);
    e = q.pop_front(); checks++;
    if (p !== e.v) $display("FAIL %s: got %h expected %h", e.name, p, e.v); else passes++;
    q.push_back('{"dying_59", mk(2'd2, 1, 1'b0, 1'b0)});
    repeat (59) stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    q.push_back('{"over_60", mk(2'd3, 1, 1'b0, 1'b0)});
    stb();
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    q.push_back('{"over_to_idle", mk(2'd0, 1, 1'b0, 1'b0)});
    press(p);
    e = q.pop_front(); checks++;
    if (p !== e.v) $display("FAIL %s: got %h expected %h", e.name, p, e.v); else passes++;
    q.push_back('{"idle_restart", mk(2'd1, 0, 1'b1, 1'b1)});
    press(p);
    e = q.pop_front(); checks++;
    if (p !== e.v) $display("FAIL %s: got %h expected %h", e.name, p, e.v); else passes++;
  endtask

  task automatic test_back_to_back();
    set_bird(330, 370, 200, 240);
    set_pipe(280, 320);
    i_btn = 1'b1;
    tick(); tick();
    i_ani_stb = 1'b1;
    q.push_back('{"flap_and_eval", mk(2'd1, 1, 1'b1, 1'b0)});
    tick();
    i_ani_stb = 1'b0;
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    i_btn = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_rst_mid();
    i_rst = 1'b1;
    q.push_back('{"rst_playing", mk(2'd0, 0, 1'b0, 1'b0)});
    tick();
    i_rst = 1'b0;
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    restart();
    set_bird(330, 370, 200, 240);
    stb();
    set_bird(300, 340, 410, 450);
    stb();
    i_rst = 1'b1;
    q.push_back('{"rst_dying", mk(2'd0, 0, 1'b0, 1'b0)});
    tick();
    i_rst = 1'b0;
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    restart();
    set_bird(330, 370, 200, 240);
    stb();
    set_bird(300, 340, 410, 450);
    repeat (61) stb();
    q.push_back('{"over_again", mk(2'd3, 1, 1'b0, 1'b0)});
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
    i_rst = 1'b1;
    q.push_back('{"rst_over", mk(2'd0, 0, 1'b0, 1'b0)});
    tick();
    i_rst = 1'b0;
    e = q.pop_front(); checks++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
  endtask

  initial begin
    i_rst = 1'b1; i_ani_stb = 1'b0; i_btn = 1'b0;
    set_bird(300, 340, 200, 240);
    set_pipe(280, 320);
    test_reset();
    test_start();
    test_collision();
    test_clear();
    test_bcd();
    test_dying_over();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
